// File: rtl/data_path_mc.sv
// data_path_mc: multi-cycle CPU data path sequencing fetch/exec/mem/writeback over handshaked memories
module data_path_mc #(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 8,
  parameter int DADDR_W  = 9,
  parameter int REG_AW   = 3,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  input  logic               resume,
  output logic               halted,
  output logic               retire,
  output logic [PC_W-1:0]    pc
);
  localparam logic [2:0] S_FETCH = 3'd0, S_EXEC = 3'd1, S_MEM = 3'd2, S_WB = 3'd3, S_HALT = 3'd4;
  logic [2:0] r_state;
  logic r_run, r_wen;
  logic [PC_W-1:0] r_pc, r_tgt;
  logic [15:0] r_ir;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_regs [2**REG_AW];
  logic [3:0] w_op;
  logic [REG_AW-1:0] w_rd, w_rs;
  logic [DATA_W-1:0] w_a, w_b, w_simm, w_alu;
  logic [PC_W-1:0] w_pc1, w_tgt;
  assign w_op = r_ir[15:12];
  assign w_rd = r_ir[9 +: REG_AW];
  assign w_rs = r_ir[6 +: REG_AW];
  assign w_a = r_regs[w_rd];
  assign w_b = r_regs[w_rs];
  assign w_simm = DATA_W'($signed(r_ir[8:0]));
  assign w_pc1 = r_pc + PC_W'(1);
  always_comb
    w_alu = w_op == 4'd0 ? w_a + w_b :
            w_op == 4'd1 ? w_a + w_simm :
            w_op == 4'd2 ? w_a - w_b :
            w_op == 4'd3 ? w_a & w_b :
            w_op == 4'd4 ? w_a | w_b : w_a << r_ir[3:0];
  assign w_tgt = w_op == 4'd8 ? PC_W'(r_ir[8:0]) :
                 (w_op == 4'd9 && w_a[DATA_W-1]) ? r_pc + PC_W'($signed(r_ir[8:0])) : w_pc1;
  assign imem_req = r_run && r_state == S_FETCH;
  assign imem_addr = r_pc;
  assign dmem_req = r_state == S_MEM;
  assign dmem_we = dmem_req && w_op == 4'd7;
  assign dmem_addr = r_ir[DADDR_W-1:0];
  assign dmem_wdata = w_a;
  assign halted = r_state == S_HALT;
  assign retire = r_state == S_WB || (halted && resume);
  assign pc = r_pc;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run <= 1'b0;
      r_pc <= PC_W'(RESET_PC);
      r_tgt <= '0;
      r_ir <= '0;
      r_res <= '0;
      r_wen <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_FETCH: if (imem_req && imem_ready) begin
          r_ir <= imem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= w_alu;
          r_tgt <= w_tgt;
          r_wen <= w_op <= 4'd6;
          r_state <= (w_op == 4'd6 || w_op == 4'd7) ? S_MEM : w_op == 4'hF ? S_HALT : S_WB;
        end
        S_MEM: if (dmem_ready) begin
          if (!dmem_we) r_res <= dmem_rdata;
          r_state <= S_WB;
        end
        S_WB: begin
          if (r_wen) r_regs[w_rd] <= r_res;
          r_pc <= r_tgt;
          r_state <= S_FETCH;
        end
        S_HALT: if (resume) begin
          r_pc <= w_pc1;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
endmodule

// File: tb/tb_data_path_mc.sv
// tb_data_path_mc: ISA-level model plus directed programs checking data_path_mc every cycle
module tb_data_path_mc;
  logic clk, rst_n, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, resume, halted, retire;
  logic [7:0] imem_addr, pc;
  logic [15:0] imem_rdata, dmem_wdata, dmem_rdata;
  logic [8:0] dmem_addr;
  logic [15:0] rom [256];
  logic [15:0] ram [512];
  logic [15:0] m_mem [512];
  logic [15:0] m_r [8];
  logic [7:0] m_pc;
  logic i_force;
  int i_wait, d_wait, ic, dc, cyc_n, checks, failures;
  logic [7:0] ret_pc [$];
  int ret_cyc [$];

  data_path_mc dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .resume(resume),
    .halted(halted), .retire(retire), .pc(pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign imem_rdata = rom[imem_addr];
  assign dmem_rdata = ram[dmem_addr];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    ram[a] = v;
    m_mem[a] = v;
  endtask

  task automatic load_nop();
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000;
  endtask

  task automatic rst_seq();
    cyc();
    rst_n = 0;
    cyc();
    cyc();
    ret_pc.delete();
    ret_cyc.delete();
    rst_n = 1;
  endtask

  task automatic step();
    logic [15:0] ir, s;
    logic [2:0] rd, rs;
    logic [8:0] im;
    logic [7:0] np;
    ir = rom[m_pc];
    rd = ir[11:9];
    rs = ir[8:6];
    im = ir[8:0];
    s = {{7{im[8]}}, im};
    np = m_pc + 8'd1;
    case (ir[15:12])
      4'd0: m_r[rd] = m_r[rd] + m_r[rs];
      4'd1: m_r[rd] = m_r[rd] + s;
      4'd2: m_r[rd] = m_r[rd] - m_r[rs];
      4'd3: m_r[rd] = m_r[rd] & m_r[rs];
      4'd4: m_r[rd] = m_r[rd] | m_r[rs];
      4'd5: m_r[rd] = m_r[rd] << ir[3:0];
      4'd6: m_r[rd] = m_mem[im];
      4'd7: m_mem[im] = m_r[rd];
      4'd8: np = im[7:0];
      4'd9: if (m_r[rd][15]) np = m_pc + s[7:0];
      default: ;
    endcase
    m_pc = np;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    ic = imem_req ? ic + 1 : 0;
    dc = dmem_req ? dc + 1 : 0;
    imem_ready = i_force || (imem_req && ic >= i_wait);
    dmem_ready = dmem_req && dc >= d_wait;
  end

  initial forever begin
    @(negedge clk);
    if (dmem_req && dmem_ready && dmem_we) ram[dmem_addr] = dmem_wdata;
  end

  initial begin
    logic [15:0] ir;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        m_pc = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
      end else begin
        ir = rom[m_pc];
        chk("pc", pc, m_pc);
        if (imem_req) chk("imem_addr", imem_addr, m_pc);
        if (dmem_req) begin
          chk("dmem_op", ir[15:13] == 3'b011, 1);
          chk("dmem_we", dmem_we, ir[12]);
          chk("dmem_addr", dmem_addr, ir[8:0]);
          if (ir[12]) chk("dmem_wdata", dmem_wdata, m_r[ir[11:9]]);
        end
        if (halted) chk("halt_op", ir[15:12], 4'hF);
        if (retire) begin
          if (ir[15:12] == 4'hF) chk("stp_resume", resume, 1);
          ret_pc.push_back(pc);
          ret_cyc.push_back(cyc_n);
          step();
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, k;
    logic [7:0] exp_c [12];
    exp_c = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF, 8'h00, 8'h08};
    checks = 0;
    failures = 0;
    cyc_n = 0;
    ic = 0;
    dc = 0;
    rst_n = 0;
    resume = 0;
    i_force = 1;
    imem_ready = 1;
    dmem_ready = 0;
    i_wait = 1;
    d_wait = 1;
    load_nop();
    for (int i = 0; i < 512; i++) poke(i, 16'h0);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_dmem_req", dmem_req, 0);
    rom[0] = 16'h1205; rom[1] = 16'h13F9; rom[2] = 16'h0440; rom[3] = 16'h7220;
    rom[4] = 16'h7421; rom[5] = 16'h2680; rom[6] = 16'h34C0; rom[7] = 16'h4640;
    rom[8] = 16'h5204; rom[9] = 16'h1803; rom[10] = 16'h0900; rom[11] = 16'h7222;
    rom[12] = 16'h7423; rom[13] = 16'h7624; rom[14] = 16'h7825; rom[15] = 16'hA000;
    rom[16] = 16'hF000; rom[17] = 16'h8011;
    cyc();
    i_force = 0;
    ret_pc.delete();
    ret_cyc.delete();
    rst_n = 1;
    for (n = 0; n < 4 && !imem_req; n++) @(negedge clk);
    chk("rel_imem_req", imem_req, 1);
    chk("rel_imem_addr", imem_addr, 0);
    repeat (2) cyc();
    resume = 1;
    repeat (3) cyc();
    resume = 0;
    for (n = 0; n < 400 && !halted; n++) @(negedge clk);
    chk("a_halted", halted, 1);
    chk("a_halt_pc", pc, 16);
    chk("a_r1", ram[9'h20], 16'hFFFE);
    chk("a_r2", ram[9'h21], 16'hFFFE);
    chk("a_shl", ram[9'h22], 16'hFFE0);
    chk("a_and", ram[9'h23], 16'h0002);
    chk("a_or", ram[9'h24], 16'hFFFE);
    chk("a_add_self", ram[9'h25], 16'h0006);
    chk("a_ret_gap1", ret_cyc[1] - ret_cyc[0], 3);
    chk("a_ret_gap2", ret_cyc[2] - ret_cyc[1], 3);
    chk("a_pc3", ret_pc[3], 3);
    k = 0;
    repeat (10) begin
      cyc();
      @(negedge clk);
      k += int'(imem_req) + int'(!halted);
    end
    chk("a_halt_hold", k, 0);
    cyc();
    resume = 1;
    @(negedge clk);
    chk("a_resume_retire", retire, 1);
    cyc();
    resume = 0;
    for (n = 0; n < 10 && !imem_req; n++) @(negedge clk);
    chk("a_resume_fetch", imem_addr, 17);

    load_nop();
    rom[0] = 16'h6610; rom[1] = 16'h77FF; rom[2] = 16'hF000; rom[3] = 16'h8003;
    poke(9'h10, 16'h1234);
    poke(9'h1FF, 16'h0);
    d_wait = 4;
    rst_seq();
    for (n = 0; n < 50 && !dmem_req; n++) @(negedge clk);
    k = 0;
    while (dmem_req && k < 50) begin
      chk("b_lw_addr", dmem_addr, 9'h010);
      chk("b_lw_we", dmem_we, 0);
      k++;
      @(negedge clk);
    end
    chk("b_lw_len", k, 4);
    for (n = 0; n < 50 && !dmem_req; n++) @(negedge clk);
    k = 0;
    while (dmem_req && k < 50) begin
      chk("b_sw_we", dmem_we, 1);
      chk("b_sw_addr", dmem_addr, 9'h1FF);
      chk("b_sw_wdata", dmem_wdata, 16'h1234);
      k++;
      @(negedge clk);
    end
    chk("b_sw_len", k, 4);
    for (n = 0; n < 50 && !halted; n++) @(negedge clk);
    chk("b_halted", halted, 1);
    chk("b_ram", ram[9'h1FF], 16'h1234);

    load_nop();
    rom[0] = 16'h9408; rom[1] = 16'h6230; rom[2] = 16'h8005; rom[3] = 16'h6231;
    rom[4] = 16'h8005; rom[5] = 16'h93FE; rom[6] = 16'h6430; rom[7] = 16'h80FF;
    rom[9] = 16'hF000; rom[11] = 16'h800B;
    poke(9'h30, 16'h8000);
    poke(9'h31, 16'h7FFF);
    d_wait = 1;
    rst_seq();
    for (n = 0; n < 500 && !halted; n++) @(negedge clk);
    chk("c_halted", halted, 1);
    chk("c_halt_pc", pc, 9);
    chk("c_ret_count", ret_pc.size(), 12);
    for (int i = 0; i < 12; i++) chk("c_ret_pc", ret_pc[i], exp_c[i]);
    k = 0;
    repeat (10) begin
      cyc();
      @(negedge clk);
      k += int'(imem_req);
    end
    chk("c_no_req", k, 0);
    cyc();
    resume = 1;
    cyc();
    resume = 0;
    for (n = 0; n < 10 && !imem_req; n++) @(negedge clk);
    chk("c_resume_addr", imem_addr, 8'h0A);

    load_nop();
    rom[0] = 16'h1609; rom[1] = 16'h6610;
    d_wait = 20;
    rst_seq();
    for (n = 0; n < 50 && !dmem_req; n++) @(negedge clk);
    chk("d_req_seen", dmem_req, 1);
    repeat (3) cyc();
    rst_n = 0;
    cyc();
    @(negedge clk);
    chk("d_drop_dreq", dmem_req, 0);
    chk("d_drop_ireq", imem_req, 0);
    cyc();
    rom[0] = 16'h7640; rom[1] = 16'hF000; rom[2] = 16'h8002;
    poke(9'h40, 16'hDEAD);
    d_wait = 1;
    cyc();
    rst_n = 1;
    for (n = 0; n < 100 && !halted; n++) @(negedge clk);
    chk("d_halted", halted, 1);
    chk("d_r3_clear", ram[9'h40], 16'h0000);
    chk("d_halt_pc", pc, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
